extract: RTL

//  Strips a fixed-size header struct from the front of an AXIS packet stream.

---
 rtl/extract.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/extract.sv
// Strips a fixed-size header struct from the front of an AXIS packet, emits it on
// its own stream, and re-aligns the remaining payload to byte 0.
module extract #(
    parameter int BUF_DATA_WIDTH         = 256,
    parameter int BUF_KEEP_WIDTH         = BUF_DATA_WIDTH/8,
    parameter int EXTRACTED_STRUCT_WIDTH = 112
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BUF_DATA_WIDTH-1:0]         s_inbuf_axis_tdata,
    input  logic [BUF_KEEP_WIDTH-1:0]         s_inbuf_axis_tkeep,
    input  logic                              s_inbuf_axis_tvalid,
    output logic                              s_inbuf_axis_tready,
    input  logic                              s_inbuf_axis_tlast,
    output logic [EXTRACTED_STRUCT_WIDTH-1:0] m_extracted_axis_tdata,
    output logic                              m_extracted_axis_tvalid,
    input  logic                              m_extracted_axis_tready,
    output logic [BUF_DATA_WIDTH-1:0]         m_outbuf_axis_tdata,
    output logic [BUF_KEEP_WIDTH-1:0]         m_outbuf_axis_tkeep,
    output logic                              m_outbuf_axis_tvalid,
    input  logic                              m_outbuf_axis_tready,
    output logic                              m_outbuf_axis_tlast,
    output logic                              extract_err
);
    localparam int K  = BUF_KEEP_WIDTH;
    localparam int S  = EXTRACTED_STRUCT_WIDTH/8;
    localparam int SW = EXTRACTED_STRUCT_WIDTH;
    localparam int SH = BUF_DATA_WIDTH - EXTRACTED_STRUCT_WIDTH;

    typedef enum logic [1:0] {HEAD, BODY, TAIL} state_t;

    state_t                    state, state_nxt;
    logic [BUF_DATA_WIDTH-1:0] in_data;
    logic [BUF_DATA_WIDTH-1:0] res_data;
    logic [K-1:0]              res_keep;
    logic [BUF_DATA_WIDTH-1:0] out_d_nxt;
    logic [K-1:0]              out_k_nxt;
    logic                      out_l_nxt;
    logic                      out_load, res_load, st_load, err_nxt;
    logic                      out_free, st_free, rdy, in_fire;
    logic                      short_hdr, long_tail;

    function automatic int popcnt(input logic [K-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < K; i++) c += int'(v[i]);
        return c;
    endfunction

    // Zero the bytes not enabled by tkeep so stale lanes never leak into outputs.
    for (genvar i = 0; i < K; i++) begin : g_lane
        assign in_data[8*i +: 8] = {8{s_inbuf_axis_tkeep[i]}} & s_inbuf_axis_tdata[8*i +: 8];
    end

    assign out_free  = !m_outbuf_axis_tvalid || m_outbuf_axis_tready;
    assign st_free   = !m_extracted_axis_tvalid || m_extracted_axis_tready;
    assign short_hdr = popcnt(s_inbuf_axis_tkeep) < S;
    assign long_tail = popcnt(s_inbuf_axis_tkeep) > S;

    always_comb begin
        rdy = 1'b0;
        case (state)
            HEAD:    rdy = out_free && st_free;
            BODY:    rdy = out_free;
            default: rdy = 1'b0;
        endcase
    end

    assign s_inbuf_axis_tready = rdy;
    assign in_fire             = rdy && s_inbuf_axis_tvalid;

    always_comb begin
        state_nxt = state;
        out_load  = 1'b0;
        out_d_nxt = m_outbuf_axis_tdata;
        out_k_nxt = m_outbuf_axis_tkeep;
        out_l_nxt = m_outbuf_axis_tlast;
        res_load  = 1'b0;
        st_load   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            HEAD: if (in_fire) begin
                st_load  = 1'b1;
                res_load = 1'b1;
                if (short_hdr) begin
                    // Truncated header: an empty closing payload beat keeps emit in step.
                    err_nxt   = 1'b1;
                    out_load  = 1'b1;
                    out_d_nxt = '0;
                    out_k_nxt = '0;
                    out_l_nxt = 1'b1;
                end else if (s_inbuf_axis_tlast) begin
                    out_load  = 1'b1;
                    out_d_nxt = in_data >> SW;
                    out_k_nxt = s_inbuf_axis_tkeep >> S;
                    out_l_nxt = 1'b1;
                end else begin
                    state_nxt = BODY;
                end
            end
            BODY: if (in_fire) begin
                res_load  = 1'b1;
                out_load  = 1'b1;
                out_d_nxt = res_data | (in_data << SH);
                out_k_nxt = res_keep | (s_inbuf_axis_tkeep << (K - S));
                out_l_nxt = 1'b0;
                if (s_inbuf_axis_tlast) begin
                    if (long_tail) begin
                        state_nxt = TAIL;
                    end else begin
                        out_l_nxt = 1'b1;
                        state_nxt = HEAD;
                    end
                end
            end
            TAIL: if (out_free) begin
                out_load  = 1'b1;
                out_d_nxt = res_data;
                out_k_nxt = res_keep;
                out_l_nxt = 1'b1;
                state_nxt = HEAD;
            end
            default: state_nxt = HEAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= HEAD;
            m_extracted_axis_tdata  <= '0;
            m_extracted_axis_tvalid <= 1'b0;
            m_outbuf_axis_tdata     <= '0;
            m_outbuf_axis_tkeep     <= '0;
            m_outbuf_axis_tvalid    <= 1'b0;
            m_outbuf_axis_tlast     <= 1'b0;
            res_data                <= '0;
            res_keep                <= '0;
            extract_err             <= 1'b0;
        end else begin
            state       <= state_nxt;
            extract_err <= err_nxt;
            if (st_load) begin
                m_extracted_axis_tdata  <= in_data[SW-1:0];
                m_extracted_axis_tvalid <= 1'b1;
            end else if (m_extracted_axis_tready) begin
                m_extracted_axis_tvalid <= 1'b0;
            end
            if (out_load) begin
                m_outbuf_axis_tdata  <= out_d_nxt;
                m_outbuf_axis_tkeep  <= out_k_nxt;
                m_outbuf_axis_tlast  <= out_l_nxt;
                m_outbuf_axis_tvalid <= 1'b1;
            end else if (m_outbuf_axis_tready) begin
                m_outbuf_axis_tvalid <= 1'b0;
            end
            if (res_load) begin
                res_data <= in_data >> SW;
                res_keep <= s_inbuf_axis_tkeep >> S;
            end
        end
    end
endmodule
